// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the staged reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE,
        ST_RUN
    } state_t;

    localparam int LOSS_CNT_W = 8;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser with asynchronous active-high clear.
module sync2 (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Staged reset sequencer: waits for PLL lock, holds, then releases channels
// one at a time in ascending order; supports selective software resets.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int HOLD_CYCLES    = 1000,
    parameter int STAGGER_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lock_in,
    input  logic                  sw_req,
    input  logic [NUM_CH-1:0]     ch_mask,
    output logic [NUM_CH-1:0]     reset_n_out,
    output logic                  busy,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_MAX = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

    state_t                  state, state_d;
    logic [CNT_W-1:0]        cnt, cnt_d;
    logic [NUM_CH-1:0]       rst_n_q, rst_n_d;
    logic [NUM_CH-1:0]       pending, pending_d;
    logic [LOSS_CNT_W-1:0]   loss_cnt, loss_cnt_d;
    logic [NUM_CH-1:0]       next_ch;
    logic                    lock_s;

    function automatic logic [NUM_CH-1:0] lowest_one(input logic [NUM_CH-1:0] m);
        logic [NUM_CH-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m[i] && !found) begin
                r[i]  = 1'b1;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    sync2 u_sync2 (
        .clk (clk),
        .clr (reset),
        .d   (lock_in),
        .q   (lock_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            rst_n_q  <= '0;
            pending  <= '1;
            loss_cnt <= '0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            rst_n_q  <= rst_n_d;
            pending  <= pending_d;
            loss_cnt <= loss_cnt_d;
        end
    end

    // pending holds the targeted channels still waiting for release
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        rst_n_d    = rst_n_q;
        pending_d  = pending;
        loss_cnt_d = loss_cnt;
        next_ch    = lowest_one(pending);

        if ((state == ST_HOLD || state == ST_RELEASE || state == ST_RUN) && !lock_s) begin
            // Lock loss wins over everything else, including a coincident sw_req
            state_d   = ST_ASSERT;
            rst_n_d   = '0;
            pending_d = '1;
            cnt_d     = '0;
            if (loss_cnt != LOSS_CNT_MAX) begin
                loss_cnt_d = loss_cnt + LOSS_CNT_W'(1);
            end
        end else begin
            case (state)
                ST_ASSERT: begin
                    rst_n_d = rst_n_q & ~pending;
                    state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end
                end
                ST_HOLD, ST_RELEASE: begin
                    if (cnt == ((state == ST_HOLD) ? HOLD_LAST : STAG_LAST)) begin
                        rst_n_d   = rst_n_q | next_ch;
                        pending_d = pending & ~next_ch;
                        cnt_d     = '0;
                        state_d   = ((pending & ~next_ch) == '0) ? ST_RUN : ST_RELEASE;
                    end else begin
                        cnt_d = cnt + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (sw_req && (ch_mask != '0)) begin
                        rst_n_d   = rst_n_q & ~ch_mask;
                        pending_d = ch_mask;
                        state_d   = ST_ASSERT;
                    end
                end
                default: state_d = ST_ASSERT;
            endcase
        end
    end

    assign reset_n_out   = rst_n_q;
    assign busy          = (state != ST_RUN);
    assign lock_loss_cnt = loss_cnt;

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: release-schedule model plus directed and random stimulus.
module tb_reset_seq;

    localparam int N = 3;
    localparam int H = 4;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         lock_in;
    logic         sw_req;
    logic [N-1:0] ch_mask;
    logic [N-1:0] reset_n_out;
    logic         busy;
    logic [7:0]   lock_loss_cnt;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    reset_seq #(.NUM_CH(N), .HOLD_CYCLES(H), .STAGGER_CYCLES(S)) dut (
        .clk           (clk),
        .reset         (reset),
        .lock_in       (lock_in),
        .sw_req        (sw_req),
        .ch_mask       (ch_mask),
        .reset_n_out   (reset_n_out),
        .busy          (busy),
        .lock_loss_cnt (lock_loss_cnt)
    );

    // Model: lock_in seen by the sequencer two edges late; channel of rank r
    // within the target set is released at hold_edge + H + r*S.
    int           ecount;
    bit           hist[$];
    bit           m_in_assert, m_waiting, m_seq, m_running;
    int           m_hold_edge;
    logic [N-1:0] m_tgt, m_rst_n;
    int           m_loss;
    bit           ls_i;
    int           r_i, last_i, rel_i;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            ecount = 0;
            hist.delete();
            m_in_assert = 1; m_waiting = 0; m_seq = 0; m_running = 0;
            m_hold_edge = 0; m_tgt = '1; m_rst_n = '0; m_loss = 0;
        end else begin
            ls_i = (hist.size() >= 2) ? hist[hist.size()-2] : 1'b0;
            if (m_in_assert) begin
                m_in_assert = 0;
                m_waiting   = 1;
            end else if (m_waiting) begin
                if (ls_i) begin
                    m_waiting   = 0;
                    m_seq       = 1;
                    m_hold_edge = ecount;
                end
            end else if ((m_seq || m_running) && !ls_i) begin
                m_rst_n = '0; m_tgt = '1;
                if (m_loss < 255) m_loss++;
                m_in_assert = 1; m_seq = 0; m_running = 0;
            end else if (m_seq) begin
                r_i = 0; last_i = -1;
                for (int c = 0; c < N; c++) begin
                    if (m_tgt[c]) begin
                        rel_i = m_hold_edge + H + r_i * S;
                        if (ecount == rel_i) m_rst_n[c] = 1'b1;
                        last_i = rel_i;
                        r_i++;
                    end
                end
                if (ecount == last_i) begin
                    m_seq = 0;
                    m_running = 1;
                end
            end else if (m_running && sw_req && ch_mask != '0) begin
                m_rst_n     = m_rst_n & ~ch_mask;
                m_tgt       = ch_mask;
                m_in_assert = 1;
                m_running   = 0;
            end
            hist.push_back(lock_in);
            if (hist.size() > 2) void'(hist.pop_front());
            ecount++;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic lit(input string nm, input logic [31:0] dut_v, input logic [31:0] mdl_v,
                       input logic [31:0] expv);
        chk({nm, "_dut"}, dut_v, expv);
        chk({nm, "_model"}, mdl_v, expv);
    endtask

    always @(negedge clk) begin
        chk("reset_n_out", reset_n_out, m_rst_n);
        chk("busy", busy, !m_running);
        chk("lock_loss_cnt", lock_loss_cnt, m_loss);
    end

    task automatic run_to(input int n);
        while (ecount < n + 1) @(negedge clk);
    endtask

    task automatic pulse_sw(input logic [N-1:0] m);
        sw_req = 1'b1; ch_mask = m;
        @(negedge clk);
        sw_req = 1'b0; ch_mask = '0;
    endtask

    task automatic wait_run(input string nm);
        int k;
        k = 0;
        while (!m_running && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk(nm, m_running, 1);
    endtask

    initial begin
        #2000000;
        $display("watchdog timeout: errors=%0d", n_err);
        $fatal(1, "bench timeout");
    end

    initial begin
        int k;
        reset = 1'b0; lock_in = 1'b1; sw_req = 1'b0; ch_mask = '0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        lit("rst_state_rstn", reset_n_out, m_rst_n, 0);
        lit("rst_state_busy", busy, !m_running, 1);
        lit("rst_state_cnt", lock_loss_cnt, m_loss, 0);
        #1 reset = 1'b0;

        // Power-up sequence
        run_to(5);  lit("pu_e5", reset_n_out, m_rst_n, 3'b000);
        run_to(6);  lit("pu_e6", reset_n_out, m_rst_n, 3'b001);
        run_to(8);  lit("pu_e8", reset_n_out, m_rst_n, 3'b001);
        run_to(9);  lit("pu_e9", reset_n_out, m_rst_n, 3'b011);
        run_to(11); lit("pu_busy11", busy, !m_running, 1);
        run_to(12); lit("pu_e12", reset_n_out, m_rst_n, 3'b111);
        lit("pu_busy12", busy, !m_running, 0);

        // Selective software reset
        k = ecount;
        pulse_sw(3'b110);
        lit("sw_k", reset_n_out, m_rst_n, 3'b001);
        run_to(k + 5); lit("sw_k5", reset_n_out, m_rst_n, 3'b001);
        run_to(k + 6); lit("sw_k6", reset_n_out, m_rst_n, 3'b011);
        run_to(k + 8); lit("sw_k8", reset_n_out, m_rst_n, 3'b011);
        run_to(k + 9); lit("sw_k9", reset_n_out, m_rst_n, 3'b111);
        lit("sw_busy", busy, !m_running, 0);

        // Lock loss during RELEASE
        k = ecount;
        pulse_sw(3'b111);
        run_to(k + 6); lit("ll_k6", reset_n_out, m_rst_n, 3'b001);
        lock_in = 1'b0;
        run_to(k + 8); lit("ll_k8", reset_n_out, m_rst_n, 3'b001);
        run_to(k + 9); lit("ll_k9", reset_n_out, m_rst_n, 3'b000);
        lit("ll_cnt", lock_loss_cnt, m_loss, 1);
        lock_in = 1'b1;
        run_to(k + 15); lit("ll_k15", reset_n_out, m_rst_n, 3'b000);
        run_to(k + 16); lit("ll_k16", reset_n_out, m_rst_n, 3'b001);
        run_to(k + 22); lit("ll_k22", reset_n_out, m_rst_n, 3'b111);

        // sw_req coincident with lock loss
        lock_in = 1'b0;
        @(negedge clk); @(negedge clk);
        pulse_sw(3'b010);
        lit("co_rstn", reset_n_out, m_rst_n, 3'b000);
        lit("co_cnt", lock_loss_cnt, m_loss, 2);
        lock_in = 1'b1;
        wait_run("co_relock_run");
        lit("co_relock", reset_n_out, m_rst_n, 3'b111);

        // Ignored requests: zero mask in RUN, sw_req in HOLD
        pulse_sw(3'b000);
        lit("zm_rstn", reset_n_out, m_rst_n, 3'b111);
        lit("zm_busy", busy, !m_running, 0);
        k = ecount;
        pulse_sw(3'b111);
        run_to(k + 3);
        pulse_sw(3'b001);
        lit("hold_k4", reset_n_out, m_rst_n, 3'b000);
        run_to(k + 6);  lit("hold_k6", reset_n_out, m_rst_n, 3'b001);
        run_to(k + 12); lit("hold_k12", reset_n_out, m_rst_n, 3'b111);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) lock_in = ~lock_in;
            sw_req  = ($urandom_range(0, 15) == 0);
            ch_mask = N'($urandom_range(0, 7));
            @(negedge clk);
        end
        sw_req = 1'b0; ch_mask = '0; lock_in = 1'b1;
        wait_run("rnd_settle_run");

        // Saturation
        for (int i = 0; i < 300; i++) begin
            lock_in = 1'b1;
            repeat (4) @(negedge clk);
            lock_in = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (4) @(negedge clk);
        lit("sat_cnt", lock_loss_cnt, m_loss, 255);

        // Asynchronous reset mid-HOLD
        lock_in = 1'b1;
        k = 0;
        while (!(m_seq && m_rst_n == '0 && ecount > m_hold_edge + 1) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("hold_reached", (m_seq && m_rst_n == '0) ? 1 : 0, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        lit("ar_rstn", reset_n_out, m_rst_n, 3'b000);
        lit("ar_busy", busy, !m_running, 1);
        lit("ar_cnt", lock_loss_cnt, m_loss, 0);
        @(negedge clk);
        #1 reset = 1'b0;
        run_to(5);  lit("ar_e5", reset_n_out, m_rst_n, 3'b000);
        run_to(6);  lit("ar_e6", reset_n_out, m_rst_n, 3'b001);
        run_to(12); lit("ar_e12", reset_n_out, m_rst_n, 3'b111);
        lit("ar_busy12", busy, !m_running, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/reset_seq.md
RESET_SEQ -- requirements
Module: reset_seq

Interface
REQ-001 Parameter NUM_CH, default 4: number of reset channels, legal 1..8.
REQ-002 Parameter HOLD_CYCLES, default 1000: clocks held after lock before the first release, legal >=1.
REQ-003 Parameter STAGGER_CYCLES, default 100: clocks between consecutive channel releases, legal >=1.
REQ-004 Port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port lock_in, input, 1: asynchronous PLL-locked indication.
REQ-007 Port sw_req, input, 1: synchronous single-cycle software reset request.
REQ-008 Port ch_mask, input, NUM_CH: selects the channels affected by sw_req; sampled with sw_req.
REQ-009 Port reset_n_out, output, NUM_CH: active-low channel resets, registered.
REQ-010 Port busy, output, 1: high whenever the state is not RUN.
REQ-011 Port lock_loss_cnt, output, 8: count of lock losses, saturating.

Function
REQ-012 lock_in SHALL pass through a two-flop synchroniser to give lock_s; only lock_s is used.
REQ-013 The FSM SHALL have states ASSERT, WAIT_LOCK, HOLD, RELEASE and RUN.
REQ-014 ASSERT: all targeted channels are driven low; the FSM moves to WAIT_LOCK on the next edge.
REQ-015 WAIT_LOCK: the FSM moves to HOLD on the first edge that samples lock_s=1, clearing the cycle counter.
REQ-016 Latency: if lock_in is first captured at edge n, the FSM enters HOLD at edge n+2.
REQ-017 HOLD: lasts exactly HOLD_CYCLES edges; on the last of these, the lowest targeted channel goes high and the FSM enters RELEASE.
REQ-018 RELEASE: each remaining targeted channel, in ascending index, goes high STAGGER_CYCLES edges after the previous one.
REQ-019 RELEASE: after the highest targeted channel is released, the FSM enters RUN on the same edge.
REQ-020 Target set: all channels after reset or lock loss; the sampled ch_mask after sw_req.
REQ-021 Non-targeted channels SHALL remain high throughout a sequence.
REQ-022 In RUN, sw_req=1 with ch_mask nonzero SHALL drive the masked channels low on the next edge and enter ASSERT.
REQ-023 sw_req with ch_mask all-zero SHALL be ignored.
REQ-024 sw_req outside RUN SHALL be ignored.
REQ-025 lock_s=0 in HOLD, RELEASE or RUN SHALL drive all channels low on the next edge, enter ASSERT and increment lock_loss_cnt.
REQ-026 lock_loss_cnt SHALL saturate at 255.
REQ-027 A lock loss and sw_req on the same edge SHALL be handled as a lock loss.
REQ-028 The counter width SHALL be $clog2(max(HOLD_CYCLES,STAGGER_CYCLES)+1); the counter does not wrap.

Reset
REQ-029 Asserting reset SHALL immediately force reset_n_out to all-zero, busy to 1, lock_loss_cnt to 0, the synchroniser to 0, the counter to 0 and the state to ASSERT.
REQ-030 Deassertion of reset SHALL release outputs only through the FSM sequence, never directly.
REQ-031 Reset asserted mid-sequence SHALL abort the sequence with no partial release.

Structure
REQ-032 Package reset_seq_pkg SHALL hold the FSM state enum and the lock_loss_cnt width constant.
REQ-033 Sub-module sync2 SHALL implement the lock_in synchroniser, with asynchronous active-high clear.

Verification
REQ-034 Power-up sequence: NUM_CH=3, HOLD=4, STAGGER=3, lock_in high before edge 0 -> ch0 high at edge 6, ch1 at edge 9, ch2 at edge 12, busy low from edge 12.
REQ-035 Selective software reset: in RUN, sw_req with ch_mask=3'b110 -> ch1 and ch2 low at the next edge with ch0 staying high; ch1 released HOLD after relock and ch2 STAGGER later.
REQ-036 Lock loss during RELEASE: lock_in dropped after ch0 is released -> all channels low, lock_loss_cnt=1, full sequence again on relock.
REQ-037 Simultaneous events and ignored requests: sw_req coincident with a lock drop -> all channels low, counter incremented; sw_req with ch_mask=0 or sw_req in HOLD -> no change.
REQ-038 Saturation: 300 lock toggles -> lock_loss_cnt holds 255.
REQ-039 Asynchronous reset: reset pulsed mid-HOLD between edges -> outputs low immediately, sequence restarts from ASSERT.
